// File: rtl/core_bus_arbiter_rr_pkg.sv
// Shared types for the core memory bus arbiter: bus word/pointer, arbiter state, index width helper.
package core_bus_arbiter_rr_pkg;

    localparam int ARB_MASTERS = 3;
    localparam int ARB_IDX_W   = (ARB_MASTERS > 1) ? $clog2(ARB_MASTERS) : 1;

    typedef logic [31:0]          word_t;
    typedef logic [29:0]          ptr_t;
    typedef logic [ARB_IDX_W-1:0] arb_idx_t;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    localparam logic [3:0] ARB_BE_ALL = 4'b1111;

    // Index width for an arbitrary master count; never below one bit.
    function automatic int arb_idx_w(input int masters);
        return (masters > 1) ? $clog2(masters) : 1;
    endfunction

endpackage

// File: rtl/core_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of req strictly after rr, wrapping modulo MASTERS.
// Purely combinational, zero latency; no backpressure of its own.
module core_arbiter_rr_pick
    import core_bus_arbiter_rr_pkg::*;
#(
    parameter int MASTERS = 3,
    parameter int IW      = arb_idx_w(MASTERS)
) (
    input  logic [MASTERS-1:0] req,
    input  logic [IW-1:0]      rr,
    output logic               vld,
    output logic [IW-1:0]      idx
);

    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            if (!vld && req[(int'(rr) + k) % MASTERS]) begin
                vld = 1'b1;
                idx = IW'((int'(rr) + k) % MASTERS);
            end
        end
    end

endmodule

// File: rtl/core_bus_arbiter_rr.sv
// N-master round-robin arbiter for the core memory bus, one transaction outstanding, per-master pending slot.
// Zero-latency issue when free; masters are held off by their pend slot until granted. Macro: CORE_ARBITER_LOCK_EN.
module core_bus_arbiter_rr
    import core_bus_arbiter_rr_pkg::*;
#(
    parameter int         MASTERS    = 3,
    parameter logic [7:0] WRITE_MASK = 8'b0000_0110
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bus_ready,
    input  logic [31:0]            bus_data_rd,
    output logic                   bus_start,
    output logic                   bus_write,
    output logic [29:0]            bus_addr,
    output logic [31:0]            bus_data_wr,
    output logic [3:0]             bus_data_be,
    input  logic [MASTERS-1:0]     m_start,
    input  logic [MASTERS-1:0]     m_write,
    input  logic [MASTERS*30-1:0]  m_addr,
    input  logic [MASTERS*32-1:0]  m_data_wr,
    input  logic [MASTERS*4-1:0]   m_data_be,
`ifdef CORE_ARBITER_LOCK_EN
    input  logic [MASTERS-1:0]     m_lock,
`endif
    output logic [MASTERS-1:0]     m_ready,
    output logic [31:0]            m_data_rd
);

    localparam int IW = arb_idx_w(MASTERS);

    arb_state_e               state_q, state_d;
    logic [IW-1:0]            owner_q, owner_d;
    logic [IW-1:0]            rr_q, rr_d;
    logic [MASTERS-1:0]       pend_q, pend_d;
    logic [MASTERS-1:0]       pend_wr_q, pend_wr_d;
    ptr_t  [MASTERS-1:0]      pend_addr_q, pend_addr_d;
    word_t [MASTERS-1:0]      pend_data_q, pend_data_d;
    logic  [MASTERS-1:0][3:0] pend_be_q, pend_be_d;

    logic               free, issue, rr_adv;
    logic [MASTERS-1:0] own_busy, start_ok, req, req_eff;
    logic               pick_vld;
    logic [IW-1:0]      pick_idx;
    logic               sel_wr;
    ptr_t               sel_addr;
    word_t              sel_data;
    logic [3:0]         sel_be;

    assign free = (state_q == ARB_IDLE) || bus_ready;

    // A master still owning an uncompleted transaction may not request again.
    always_comb begin
        own_busy = '0;
        if (state_q == ARB_BUSY && !bus_ready) own_busy[owner_q] = 1'b1;
    end

    assign start_ok = m_start & ~pend_q & ~own_busy;
    assign req      = start_ok | pend_q;

`ifdef CORE_ARBITER_LOCK_EN
    logic lock_q, lock_d, lock_act;
    logic [MASTERS-1:0] owner_oh;

    // Lock state is re-evaluated at every completion; the new value already applies to the same-cycle grant.
    assign lock_act = (state_q == ARB_BUSY && bus_ready) ? m_lock[owner_q] : lock_q;
    assign lock_d   = lock_act;
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end
    assign req_eff = lock_act ? (req & owner_oh) : req;
    assign rr_adv  = issue && !lock_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`else
    assign req_eff = req;
    assign rr_adv  = issue;
`endif

    core_arbiter_rr_pick #(.MASTERS(MASTERS), .IW(IW)) u_pick (
        .req (req_eff),
        .rr  (rr_q),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign issue = rst_n && free && pick_vld;

    always_comb begin
        if (pend_q[pick_idx]) begin
            sel_wr   = pend_wr_q[pick_idx];
            sel_addr = pend_addr_q[pick_idx];
            sel_data = pend_data_q[pick_idx];
            sel_be   = pend_be_q[pick_idx];
        end else begin
            sel_wr   = m_write[pick_idx];
            sel_addr = m_addr[int'(pick_idx)*30 +: 30];
            sel_data = m_data_wr[int'(pick_idx)*32 +: 32];
            sel_be   = m_data_be[int'(pick_idx)*4 +: 4];
        end
    end

    assign bus_start   = issue;
    assign bus_write   = issue && sel_wr && WRITE_MASK[pick_idx];
    assign bus_addr    = issue ? sel_addr : '0;
    assign bus_data_wr = issue ? sel_data : '0;
    assign bus_data_be = !issue ? 4'b0000 : (WRITE_MASK[pick_idx] ? sel_be : ARB_BE_ALL);

    always_comb begin
        m_ready = '0;
        if (state_q == ARB_BUSY) m_ready[owner_q] = bus_ready;
    end
    assign m_data_rd = bus_data_rd;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        pend_d      = pend_q;
        pend_wr_d   = pend_wr_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_be_d   = pend_be_q;
        if (free) state_d = issue ? ARB_BUSY : ARB_IDLE;
        if (issue) owner_d = pick_idx;
        if (rr_adv) rr_d = pick_idx;
        for (int i = 0; i < MASTERS; i++) begin
            if (issue && pick_idx == IW'(i)) begin
                pend_d[i] = 1'b0;
            end else if (start_ok[i]) begin
                pend_d[i]      = 1'b1;
                pend_wr_d[i]   = m_write[i];
                pend_addr_d[i] = m_addr[i*30 +: 30];
                pend_data_d[i] = m_data_wr[i*32 +: 32];
                pend_be_d[i]   = m_data_be[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_q        <= IW'(MASTERS - 1);
            pend_q      <= '0;
            pend_wr_q   <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_be_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            pend_q      <= pend_d;
            pend_wr_q   <= pend_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_be_q   <= pend_be_d;
        end
    end

    a_no_rerequest: assert property (@(posedge clk) disable iff (!rst_n)
        (m_start & (pend_q | own_busy)) == '0);

endmodule
